// File: rtl/fb_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fb_access_scheduler
//  Description : Single-port frame buffer access scheduler. Shares one
//                synchronous-read RAM port between the display scan-out
//                reader (always wins) and a host pixel writer whose writes
//                are posted into a small FIFO and drained when the port is
//                free.
//  Ports       : clk_i/rst_i        pixel clock, async active-high reset
//                disp_*             display read request / registered result
//                wr_*               host write handshake and FIFO occupancy
//                mem_*              RAM port (combinational from the grant)
//                stats_clr_i,
//                wr_stall_cnt_o     optional write-stall statistics
//  Options     : FB_SCHED_STATS_EN  enables the saturating stall counter;
//                                   when undefined wr_stall_cnt_o is 0.
//  Revision    : 1.0 - initial release
// ============================================================================

// Video-mode helpers; only defined here when the surrounding project has not
// already provided them.
`ifndef MODE_640X480X3BPPX60HZ
`define MODE_640X480X3BPPX60HZ 0
`endif
`ifndef GET_BPP
`define GET_BPP(m) (((m) == 0) ? 3 : 8)
`endif
`ifndef GET_SIMULATED_FRAME_SIZE
`define GET_SIMULATED_FRAME_SIZE(m) (((m) == 0) ? 307200 : 4096)
`endif

module fb_access_scheduler #(
    parameter int  MODE          = `MODE_640X480X3BPPX60HZ,
    parameter int  WR_FIFO_DEPTH = 4,
    localparam int DW            = `GET_BPP(MODE),
    localparam int FRAME         = `GET_SIMULATED_FRAME_SIZE(MODE),
    localparam int AW            = $clog2(FRAME),
    localparam int LW            = $clog2(WR_FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // display read side
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic [DW-1:0] disp_data_o,
    output logic          disp_valid_o,
    // host write side
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    // RAM port
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    // status / statistics
    output logic [LW-1:0] wr_level_o,
    input  logic          stats_clr_i,
    output logic [15:0]   wr_stall_cnt_o
);

    localparam int PW = $clog2(WR_FIFO_DEPTH);

    localparam logic [1:0] c_GNT_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_READ  = 2'd1;
    localparam logic [1:0] c_GNT_WRITE = 2'd2;

    localparam logic [LW-1:0] c_DEPTH = LW'(WR_FIFO_DEPTH);
    // One bit wider than the address so a power-of-two FRAME still compares.
    localparam logic [AW:0]   c_FRAME = (AW + 1)'(FRAME);

    // ------------------------------------------------------------------------
    // Posted-write FIFO state
    // ------------------------------------------------------------------------
    logic [AW-1:0] r_fifo_addr [WR_FIFO_DEPTH];
    logic [DW-1:0] r_fifo_data [WR_FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_wr_ready;

    // Read return pipeline
    logic          r_rd_pend;
    logic          r_disp_valid;
    logic [DW-1:0] r_disp_data;

    logic [1:0]    w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_head_in_range;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [LW-1:0] w_level_nxt;

    assign w_head_addr     = r_fifo_addr[r_rd_ptr];
    assign w_head_data     = r_fifo_data[r_rd_ptr];
    assign w_head_in_range = ({1'b0, w_head_addr} < c_FRAME);

    // Grant decision: memoryless, re-evaluated every cycle, reads first.
    always_comb begin
        w_grant = c_GNT_IDLE;
        if (disp_req_i) begin
            w_grant = c_GNT_READ;
        end else if (r_level != '0) begin
            w_grant = c_GNT_WRITE;
        end
    end

    // r_wr_ready already reflects "not full" for this cycle, so a pop in the
    // same cycle cannot open the door for a push.
    assign w_push = wr_valid_i & r_wr_ready;
    assign w_pop  = (w_grant == c_GNT_WRITE);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // RAM port drive. Out-of-frame writes are popped without touching the RAM.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (w_grant)
            c_GNT_READ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = disp_addr_i;
            end
            c_GNT_WRITE: begin
                if (w_head_in_range) begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = w_head_addr;
                    mem_wdata_o = w_head_data;
                end
            end
            default: begin
                mem_en_o = 1'b0;
            end
        endcase
    end

    // FIFO storage needs no reset: the pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr_i;
            r_fifo_data[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level    <= w_level_nxt;
            r_wr_ready <= (w_level_nxt < c_DEPTH);
        end
    end

    // Request in N, RAM data at N+1, registered result visible at N+2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_pend    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_rd_pend    <= (w_grant == c_GNT_READ);
            r_disp_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_disp_data <= mem_rdata_i;
            end
        end
    end

    assign disp_valid_o = r_disp_valid;
    assign disp_data_o  = r_disp_data;
    assign wr_ready_o   = r_wr_ready;
    assign wr_level_o   = r_level;

    // ------------------------------------------------------------------------
    // Write-stall statistics
    // ------------------------------------------------------------------------
`ifdef FB_SCHED_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= 16'h0000;
        end else if (stats_clr_i) begin
            r_stall_cnt <= 16'h0000;
        end else if ((r_level != '0) && (w_grant == c_GNT_READ) &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign wr_stall_cnt_o = r_stall_cnt;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr_i;
    assign wr_stall_cnt_o     = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_access_scheduler
//  Description : Scoreboard bench for fb_access_scheduler (default video mode,
//                3 bpp, 307200-pixel frame, 4-entry write FIFO). A driver
//                issues directed and $urandom stimulus and, from a queue-based
//                reference model, pushes per-cycle port expectations and read
//                results into queues; a monitor on the falling edge pops and
//                compares them. A behavioural RAM serves the DUT's RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_access_scheduler;

    localparam int AW    = 19;
    localparam int DW    = 3;
    localparam int FRAME = 307200;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          disp_req_i = 1'b0;
    logic [AW-1:0] disp_addr_i = '0;
    logic [DW-1:0] disp_data_o;
    logic          disp_valid_o;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o;
    logic [AW-1:0] wr_addr_i = '0;
    logic [DW-1:0] wr_data_i = '0;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [2:0]    wr_level_o;
    logic          stats_clr_i = 1'b0;
    logic [15:0]   wr_stall_cnt_o;

    fb_access_scheduler #(
        .WR_FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .disp_req_i     (disp_req_i),
        .disp_addr_i    (disp_addr_i),
        .disp_data_o    (disp_data_o),
        .disp_valid_o   (disp_valid_o),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .wr_level_o     (wr_level_o),
        .stats_clr_i    (stats_clr_i),
        .wr_stall_cnt_o (wr_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Behavioural single-port synchronous-read RAM (environment)
    // ------------------------------------------------------------------------
    logic [DW-1:0] ram [int];

    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                ram[int'(mem_addr_o)] = mem_wdata_o;
            end else begin
                mem_rdata_i <= ram.exists(int'(mem_addr_o)) ? ram[int'(mem_addr_o)] : '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model and scoreboard queues
    // ------------------------------------------------------------------------
    typedef struct {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            level;
        logic          ready;
        int            cnt;
    } cyc_exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    cyc_exp_t cyc_q [$];
    rd_exp_t  rd_q  [$];
    wr_t      m_q   [$];          // model of the posted-write FIFO contents
    logic [DW-1:0] m_mem [int];   // model of frame buffer contents
    logic     m_ready = 1'b0;
    int       m_cnt   = 0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : '0;
    endfunction

    // One clock cycle of stimulus. Called #1 after a rising edge; returns
    // #1 after the next rising edge.
    task automatic step(input logic req, input logic [AW-1:0] ra,
                        input logic wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic clr);
        cyc_exp_t e;
        wr_t      h;
        int       lvl;
        disp_req_i  = req;
        disp_addr_i = ra;
        wr_valid_i  = wv;
        wr_addr_i   = wa;
        wr_data_i   = wd;
        stats_clr_i = clr;

        lvl     = m_q.size();
        e.en    = 1'b0;
        e.we    = 1'b0;
        e.addr  = '0;
        e.wdata = '0;
        e.level = lvl;
        e.ready = m_ready;
`ifdef FB_SCHED_STATS_EN
        e.cnt   = m_cnt;
`else
        e.cnt   = 0;
`endif
        if (req) begin
            e.en   = 1'b1;
            e.addr = ra;
            rd_q.push_back('{cyc + 2, m_rd(ra)});
        end else if (lvl > 0) begin
            h = m_q.pop_front();
            if (int'(h.addr) < FRAME) begin
                e.en    = 1'b1;
                e.we    = 1'b1;
                e.addr  = h.addr;
                e.wdata = h.data;
                m_mem[int'(h.addr)] = h.data;
            end
        end
        cyc_q.push_back(e);

        if (wv && m_ready) m_q.push_back('{wa, wd});
        m_ready = (m_q.size() < DEPTH);

        if (clr) m_cnt = 0;
        else if (lvl > 0 && req && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;

        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset, asserted between clock edges.
    task automatic do_reset();
        disp_req_i  = 1'b0;
        wr_valid_i  = 1'b0;
        stats_clr_i = 1'b0;
        rst_i       = 1'b1;
        cyc_q.delete();
        rd_q.delete();
        m_q.delete();
        m_ready = 1'b0;
        m_cnt   = 0;
        #1;
        chk("rst disp_valid", int'(disp_valid_o), 0);
        chk("rst disp_data",  int'(disp_data_o), 0);
        chk("rst wr_ready",   int'(wr_ready_o), 0);
        chk("rst wr_level",   int'(wr_level_o), 0);
        chk("rst stall_cnt",  int'(wr_stall_cnt_o), 0);
        chk("rst mem_en",     int'(mem_en_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: pops expectations and compares on the falling edge
    // ------------------------------------------------------------------------
    cyc_exp_t mon_e;
    rd_exp_t  mon_r;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                chk("mem_en",    int'(mem_en_o), int'(mon_e.en));
                chk("mem_we",    int'(mem_we_o), int'(mon_e.we));
                chk("mem_addr",  int'(mem_addr_o), int'(mon_e.addr));
                chk("mem_wdata", int'(mem_wdata_o), int'(mon_e.wdata));
                chk("wr_level",  int'(wr_level_o), mon_e.level);
                chk("wr_ready",  int'(wr_ready_o), int'(mon_e.ready));
                chk("stall_cnt", int'(wr_stall_cnt_o), mon_e.cnt);
            end
            if (disp_valid_o) begin
                if (rd_q.size() == 0) begin
                    chk("spurious disp_valid", 1, 0);
                end else begin
                    mon_r = rd_q.pop_front();
                    chk("disp_valid latency", cyc, mon_r.cyc);
                    chk("disp_data", int'(disp_data_o), int'(mon_r.data));
                end
            end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                mon_r = rd_q.pop_front();
                chk("missing disp_valid", 0, 1);
            end
        end
    end

    function automatic logic [AW-1:0] rand_waddr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)       return AW'($urandom_range(0, 15));
        else if (r == 7) return AW'(FRAME - 1);
        else if (r == 8) return AW'(FRAME + int'($urandom_range(0, 3)));
        else             return AW'($urandom);
    endfunction

    function automatic logic [AW-1:0] rand_raddr();
        if ($urandom_range(0, 9) < 8) return AW'($urandom_range(0, 15));
        return AW'($urandom);
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int pct;
        int guard;
        logic [DW-1:0] v;

        for (int a = 0; a < 16; a++) begin
            v = DW'($urandom);
            if (a == 5) v = 3'h6;
            ram[a]   = v;
            m_mem[a] = v;
        end

        #1;
        do_reset();

        // Read of a preloaded location
        step(1'b1, 19'd5, 1'b0, '0, '0, 1'b0);
        idle_step();
        idle_step();

        // Single write with an idle display
        step(1'b0, '0, 1'b1, 19'd10, 3'h2, 1'b0);
        idle_step();
        idle_step();

        // Reads hold the port: FIFO fills, fifth write is refused
        for (int i = 0; i < 6; i++) begin
            step(1'b1, AW'(i), 1'b1, AW'(20 + i), DW'(i + 1), 1'b0);
        end
        for (int i = 0; i < 6; i++) idle_step();

        // Out-of-frame write is dropped; boundary address last in frame
        step(1'b0, '0, 1'b1, AW'(FRAME), 3'h7, 1'b0);
        step(1'b0, '0, 1'b1, AW'(FRAME - 1), 3'h5, 1'b0);
        idle_step();
        idle_step();
        step(1'b1, AW'(FRAME - 1), 1'b0, '0, '0, 1'b0);
        idle_step();
        idle_step();

        // Reset with three posted writes and a read in flight
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 19'd1, 1'b1, AW'(i), DW'(7 - i), 1'b0);
        end
        step(1'b1, 19'd2, 1'b0, '0, '0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) idle_step();

        // Randomized traffic with varying read pressure
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 10;
                    1:       pct = 50;
                    default: pct = 95;
                endcase
            end
            step($urandom_range(0, 99) < pct, rand_raddr(),
                 $urandom_range(0, 9) < 6, rand_waddr(), DW'($urandom),
                 $urandom_range(0, 49) == 0);
        end

`ifdef FB_SCHED_STATS_EN
        for (int i = 0; i < 8; i++) idle_step();
        step(1'b0, '0, 1'b1, 19'd3, 3'h1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 19'd4, 1'b0, '0, '0, 1'b0);
        step(1'b1, 19'd4, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 70000; i++) step(1'b1, 19'd4, 1'b0, '0, '0, 1'b0);
        idle_step();
`endif

        // Drain everything still posted, bounded
        guard = 0;
        while ((m_q.size() > 0 || rd_q.size() > 0) && guard < 50) begin
            idle_step();
            guard++;
        end
        idle_step();
        idle_step();
        chk("read queue drained", rd_q.size(), 0);
        chk("model FIFO drained", m_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
